ram_program_loader: RTL and testbench
=====================================

# ram_program_loader

Sequential loader that drives the RAM programming port from a byte stream: it accepts 16 bytes over a valid/ready handshake and writes them to addresses 0..15. It then reads the memory back and compares an 8-bit checksum. It sits between the front-panel/serial byte source and the 16x8 RAM. It owns the programming-mode strobe, write strobe, address and data lines for the whole session.

## Interface
Parameters:
- DATA_WIDTH, 8, byte width of stream and RAM word
- ADDR_WIDTH, 4, RAM address width; DEPTH = 2**ADDR_WIDTH words per session
- VERIFY, 1, 1 = run read-back checksum pass after loading, 0 = skip it

Ports:
- CLOCK  in  1  system clock; all state changes on rising edge
- RESET  in  1  synchronous, active-high reset
- START  in  1  begin a programming session; sampled in IDLE only
- BYTE_IN  in  DATA_WIDTH  stream data
- BYTE_VALID  in  1  BYTE_IN valid
- BYTE_READY  out  1  loader accepts BYTE_IN this cycle
- ADDR_OUT  out  ADDR_WIDTH  RAM address
- RAM_PROG_DATA  out  DATA_WIDTH  RAM programming data
- _RAM_PROG  out  1  active-low programming mode, low for the whole session
- WR_PROG  out  1  RAM programming write strobe
- EN_RAM_OUT  out  1  RAM read enable, used during verify
- RAM_OUT  in  DATA_WIDTH  RAM read data; combinational from ADDR_OUT
- BUSY  out  1  session in progress
- DONE  out  1  one-cycle pulse at session end
- VERIFY_ERR  out  1  sticky checksum mismatch flag, cleared by START

## Operation
- States: IDLE, LOAD, WRITE, VERIFY, FINISH.
- IDLE:
  - _RAM_PROG=1; all other outputs 0.
  - START=1 → LOAD. On that transition: addr←0, wsum←0, rsum←0, VERIFY_ERR←0.
- LOAD:
  - BYTE_READY=1.
  - On BYTE_VALID&BYTE_READY: RAM_PROG_DATA←BYTE_IN, wsum←wsum+BYTE_IN (mod 2**DATA_WIDTH), → WRITE.
- WRITE:
  - WR_PROG=1 for exactly one cycle with stable ADDR_OUT and RAM_PROG_DATA.
  - If addr≠DEPTH-1: addr←addr+1, → LOAD.
  - If addr=DEPTH-1: if VERIFY=1 then addr←0, → VERIFY; otherwise → FINISH.
- VERIFY:
  - EN_RAM_OUT=1; rsum←rsum+RAM_OUT each cycle; addr increments.
  - After the addr=DEPTH-1 cycle → FINISH.
- FINISH:
  - VERIFY_ERR←(rsum≠wsum) when VERIFY=1.
  - DONE=1 for one cycle; → IDLE.
- BUSY=1 in every state except IDLE. _RAM_PROG=0 whenever BUSY=1.
- START while BUSY is ignored. There is no abort input; a session always covers all DEPTH words.
- Address wrap: addr never wraps inside a phase; the last word is detected by compare, not by overflow.

## Timing
- Reset values:
  - State IDLE.
  - _RAM_PROG=1.
  - ADDR_OUT=0, RAM_PROG_DATA=0.
  - WR_PROG, EN_RAM_OUT, BYTE_READY, BUSY, DONE, VERIFY_ERR all 0.
  - Internal sums 0.
- All outputs are registered or decoded from state only. No output depends combinationally on BYTE_VALID, START or RAM_OUT.
- Session latency:
  - The cycle after START, BYTE_READY=1.
  - Each byte costs at least 2 cycles (LOAD accept + WRITE).
  - Minimum session with a back-to-back stream: 1 + 2·DEPTH + DEPTH·VERIFY + 1 cycles. That is 50 cycles at defaults.
- The RAM captures the word at the rising edge that ends the WRITE cycle. ADDR_OUT and RAM_PROG_DATA do not change during WRITE.
- BYTE_READY is 0 in WRITE; the source must hold BYTE_VALID/BYTE_IN until accepted.
- RESET mid-session:
  - Next cycle is IDLE with _RAM_PROG=1 and WR_PROG=0.
  - Words already written stay in RAM.
  - VERIFY_ERR clears and DONE does not pulse.
- RESET and START asserted together: RESET wins.

## Structure
- Shared package holds:
  - The state enum (IDLE, LOAD, WRITE, VERIFY, FINISH).
  - The default DATA_WIDTH/ADDR_WIDTH constants, also used by the RAM.
- Single module. The checksum accumulator may be a sub-module `byte_checksum`: clear, add enable, data in, sum out. It is instantiated twice, for wsum and rsum.

## Test plan
- Reset then idle: hold RESET 2 cycles → _RAM_PROG=1, all other outputs 0; START during RESET has no effect.
- Full load, clean: START, stream 0x00..0x0F back-to-back against a RAM model. Required response:
  - 16 WR_PROG pulses at addresses 0..15.
  - RAM holds 0x00..0x0F.
  - DONE pulses at cycle 50, VERIFY_ERR=0.
- Stalled stream: insert 3 idle cycles before byte 5 → BYTE_READY stays 1, no WR_PROG during the stall, final RAM contents are correct.
- Verify failure: RAM model forces word 7 to read 0xFF while 0x07 was written → VERIFY_ERR=1 after DONE, held until the next START.
- Reset mid-session: RESET after the 6th WR_PROG → next cycle _RAM_PROG=1 and BUSY=0, no DONE; RAM words 0..5 written, 6..15 untouched.
- VERIFY=0 build: same stream → EN_RAM_OUT never 1, DONE at cycle 34, VERIFY_ERR stays 0.

Source files
------------

// File: rtl/ram_program_loader_pkg.sv
// rtl/ram_program_loader_pkg.sv - shared constants and state encoding for the RAM program loader
package ram_program_loader_pkg;

    // Default geometry of the 16x8 programming RAM, shared with the RAM itself
    localparam int RPL_DATA_WIDTH = 8;
    localparam int RPL_ADDR_WIDTH = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_VERIFY = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

endpackage

// File: rtl/ram_program_loader_checksum.sv
// rtl/ram_program_loader_checksum.sv - modulo-2**DATA_WIDTH byte accumulator
module byte_checksum
    import ram_program_loader_pkg::*;
#(
    parameter int DATA_WIDTH = RPL_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clear,
    input  logic                  i_add,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_sum
);

    logic [DATA_WIDTH-1:0] r_sum;

    // Clear has priority over add so a session start always begins from zero
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_sum <= '0;
        end else if (i_add) begin
            r_sum <= r_sum + i_data;
        end
    end

    assign o_sum = r_sum;

endmodule

// File: rtl/ram_program_loader.sv
// rtl/ram_program_loader.sv - loads 16 stream bytes into the RAM and verifies them by checksum
module ram_program_loader
    import ram_program_loader_pkg::*;
#(
    parameter int DATA_WIDTH = RPL_DATA_WIDTH,
    parameter int ADDR_WIDTH = RPL_ADDR_WIDTH,
    parameter int VERIFY     = 1
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic [DATA_WIDTH-1:0] BYTE_IN,
    input  logic                  BYTE_VALID,
    output logic                  BYTE_READY,
    output logic [ADDR_WIDTH-1:0] ADDR_OUT,
    output logic [DATA_WIDTH-1:0] RAM_PROG_DATA,
    output logic                  _RAM_PROG,
    output logic                  WR_PROG,
    output logic                  EN_RAM_OUT,
    input  logic [DATA_WIDTH-1:0] RAM_OUT,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  VERIFY_ERR
);

    localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_verify_err;
    logic                  r_ready;
    logic                  r_ram_prog_n;
    logic                  r_wr_prog;
    logic                  r_en_ram_out;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_start;
    logic                  w_accept;
    logic                  w_last;
    logic                  w_verify_add;
    logic [DATA_WIDTH-1:0] w_wsum;
    logic [DATA_WIDTH-1:0] w_rsum;

    assign w_start      = (r_state == ST_IDLE) && START;
    assign w_accept     = (r_state == ST_LOAD) && BYTE_VALID;
    assign w_last       = (r_addr == LAST_ADDR);
    assign w_verify_add = (r_state == ST_VERIFY);

    // Next-state decode; the last word is found by address compare, never by wrap
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (START) w_next_state = ST_LOAD;
            ST_LOAD:   if (BYTE_VALID) w_next_state = ST_WRITE;
            ST_WRITE: begin
                if (!w_last) begin
                    w_next_state = ST_LOAD;
                end else if (VERIFY != 0) begin
                    w_next_state = ST_VERIFY;
                end else begin
                    w_next_state = ST_FINISH;
                end
            end
            ST_VERIFY: if (w_last) w_next_state = ST_FINISH;
            ST_FINISH: w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Session FSM: state, address/data datapath and outputs registered from the next state
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_data       <= '0;
            r_verify_err <= 1'b0;
            r_ready      <= 1'b0;
            r_ram_prog_n <= 1'b1;
            r_wr_prog    <= 1'b0;
            r_en_ram_out <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (START) begin
                        r_addr       <= '0;
                        r_verify_err <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (BYTE_VALID) begin
                        r_data <= BYTE_IN;
                    end
                end
                ST_WRITE: begin
                    // Address and data stay put for the whole write cycle
                    if (!w_last) begin
                        r_addr <= r_addr + 1'b1;
                    end else if (VERIFY != 0) begin
                        r_addr <= '0;
                    end
                end
                ST_VERIFY: begin
                    if (!w_last) begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                ST_FINISH: begin
                    if (VERIFY != 0) begin
                        r_verify_err <= (w_rsum != w_wsum);
                    end
                    // Return the bus to its quiet idle values
                    r_addr <= '0;
                    r_data <= '0;
                end
                default: begin
                    r_addr <= '0;
                end
            endcase

            r_state      <= w_next_state;
            r_ready      <= (w_next_state == ST_LOAD);
            r_ram_prog_n <= (w_next_state == ST_IDLE);
            r_wr_prog    <= (w_next_state == ST_WRITE);
            r_en_ram_out <= (w_next_state == ST_VERIFY);
            r_busy       <= (w_next_state != ST_IDLE);
            r_done       <= (w_next_state == ST_FINISH);
        end
    end

    byte_checksum #(.DATA_WIDTH(DATA_WIDTH)) u_wsum (
        .i_clk   (CLOCK),
        .i_rst   (RESET),
        .i_clear (w_start),
        .i_add   (w_accept),
        .i_data  (BYTE_IN),
        .o_sum   (w_wsum)
    );

    byte_checksum #(.DATA_WIDTH(DATA_WIDTH)) u_rsum (
        .i_clk   (CLOCK),
        .i_rst   (RESET),
        .i_clear (w_start),
        .i_add   (w_verify_add),
        .i_data  (RAM_OUT),
        .o_sum   (w_rsum)
    );

    assign BYTE_READY    = r_ready;
    assign ADDR_OUT      = r_addr;
    assign RAM_PROG_DATA = r_data;
    assign _RAM_PROG     = r_ram_prog_n;
    assign WR_PROG       = r_wr_prog;
    assign EN_RAM_OUT    = r_en_ram_out;
    assign BUSY          = r_busy;
    assign DONE          = r_done;
    assign VERIFY_ERR    = r_verify_err;

endmodule

// File: tb/tb_ram_program_loader.sv
// tb/tb_ram_program_loader.sv - directed self-checking bench for ram_program_loader
module tb_ram_program_loader;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       start_v = 1'b0;
    logic       start_n = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_in = 8'h00;

    logic       ready_v, ready_n;
    logic [3:0] addr_v, addr_n;
    logic [7:0] pdata_v, pdata_n;
    logic       prog_n_v, prog_n_n;
    logic       wr_v, wr_n;
    logic       en_v, en_n;
    logic [7:0] ramout_v, ramout_n;
    logic       busy_v, busy_n;
    logic       done_v, done_n;
    logic       verr_v, verr_n;

    logic [7:0] mem_v [16];
    logic [7:0] mem_n [16];
    logic       fill_req = 1'b0;
    logic       force_bad = 1'b0;

    int         n_cmp = 0;
    int         n_bad = 0;

    ram_program_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .VERIFY(1)) u_dut_v (
        .CLOCK(clk), .RESET(rst), .START(start_v), .BYTE_IN(byte_in), .BYTE_VALID(byte_valid),
        .BYTE_READY(ready_v), .ADDR_OUT(addr_v), .RAM_PROG_DATA(pdata_v), ._RAM_PROG(prog_n_v),
        .WR_PROG(wr_v), .EN_RAM_OUT(en_v), .RAM_OUT(ramout_v), .BUSY(busy_v), .DONE(done_v),
        .VERIFY_ERR(verr_v)
    );

    ram_program_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .VERIFY(0)) u_dut_n (
        .CLOCK(clk), .RESET(rst), .START(start_n), .BYTE_IN(byte_in), .BYTE_VALID(byte_valid),
        .BYTE_READY(ready_n), .ADDR_OUT(addr_n), .RAM_PROG_DATA(pdata_n), ._RAM_PROG(prog_n_n),
        .WR_PROG(wr_n), .EN_RAM_OUT(en_n), .RAM_OUT(ramout_n), .BUSY(busy_n), .DONE(done_n),
        .VERIFY_ERR(verr_n)
    );

    // RAM models: capture at the edge ending a programming write
    always @(posedge clk) begin
        if (fill_req) begin
            for (int i = 0; i < 16; i++) begin
                mem_v[i] <= 8'hAA;
                mem_n[i] <= 8'hAA;
            end
        end else begin
            if (wr_v && !prog_n_v) mem_v[addr_v] <= pdata_v;
            if (wr_n && !prog_n_n) mem_n[addr_n] <= pdata_n;
        end
    end

    assign ramout_v = (force_bad && addr_v == 4'd7) ? 8'hFF : mem_v[addr_v];
    assign ramout_n = mem_n[addr_n];

    logic       sel = 1'b0;
    logic       d_ready, d_wr, d_en, d_done, d_verr, d_prog_n, d_busy;
    logic [3:0] d_addr;
    logic [7:0] d_pdata;
    assign d_ready  = sel ? ready_n  : ready_v;
    assign d_wr     = sel ? wr_n     : wr_v;
    assign d_en     = sel ? en_n     : en_v;
    assign d_done   = sel ? done_n   : done_v;
    assign d_verr   = sel ? verr_n   : verr_v;
    assign d_prog_n = sel ? prog_n_n : prog_n_v;
    assign d_busy   = sel ? busy_n   : busy_v;
    assign d_addr   = sel ? addr_n   : addr_v;
    assign d_pdata  = sel ? pdata_n  : pdata_v;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_ram();
        fill_req = 1'b1;
        tick();
        fill_req = 1'b0;
    endtask

    // Drives one session with stream 0x00..0x0F; START cycle is cycle 1
    task automatic run_session(input bit which, input int stall_at, input int stall_len,
                               input int rst_after_wr, output int done_cyc, output int wr_cnt,
                               output bit addr_ok, output bit stall_ok, output bit en_seen,
                               output bit verr_at2);
        int  idx;
        int  stall_cnt;
        bit  stop;
        bit  stalling;
        bit  accepted;
        sel       = which;
        idx       = 0;
        stall_cnt = 0;
        stop      = 1'b0;
        done_cyc  = -1;
        wr_cnt    = 0;
        addr_ok   = 1'b1;
        stall_ok  = 1'b1;
        en_seen   = 1'b0;
        verr_at2  = 1'b1;
        if (which) start_n = 1'b1; else start_v = 1'b1;
        byte_in    = 8'h00;
        byte_valid = (stall_at != 0);
        tick();
        start_v = 1'b0;
        start_n = 1'b0;
        for (int cyc = 2; cyc <= 120 && done_cyc < 0 && !stop; cyc++) begin
            if (cyc == 2) verr_at2 = d_verr;
            if (d_en) en_seen = 1'b1;
            if (d_done) done_cyc = cyc;
            if (d_wr) begin
                if (d_addr !== wr_cnt[3:0] || d_pdata !== 8'(wr_cnt)) addr_ok = 1'b0;
                wr_cnt++;
            end
            if (rst_after_wr > 0 && wr_cnt == rst_after_wr) begin
                rst        = 1'b1;
                byte_valid = 1'b0;
                tick();
                rst  = 1'b0;
                stop = 1'b1;
            end else begin
                stalling = (idx == stall_at) && (stall_cnt < stall_len) && d_ready;
                if (stalling && d_wr) stall_ok = 1'b0;
                byte_valid = !stalling && (idx < 16);
                byte_in    = 8'(idx);
                accepted   = byte_valid && d_ready;
                tick();
                if (stalling) begin
                    stall_cnt++;
                    if (!d_ready || d_wr) stall_ok = 1'b0;
                end
                if (accepted) idx++;
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        start_v = 1'b1;
        start_n = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({prog_n_v, busy_v, ready_v, wr_v, en_v, done_v, verr_v, addr_v, pdata_v} !== {1'b1, 18'd0}) begin
            n_bad++;
            $display("FAIL reset_outputs_v: got prog_n=%b busy=%b rdy=%b wr=%b en=%b done=%b verr=%b addr=%h data=%h, want prog_n=1 rest 0",
                     prog_n_v, busy_v, ready_v, wr_v, en_v, done_v, verr_v, addr_v, pdata_v);
        end
        n_cmp++;
        if ({prog_n_n, busy_n, ready_n, wr_n, en_n, done_n, verr_n, addr_n, pdata_n} !== {1'b1, 18'd0}) begin
            n_bad++;
            $display("FAIL reset_outputs_n: got prog_n=%b busy=%b, want prog_n=1 busy=0", prog_n_n, busy_n);
        end
        rst     = 1'b0;
        start_v = 1'b0;
        start_n = 1'b0;
        tick();
        n_cmp++;
        if (busy_v !== 1'b0 || prog_n_v !== 1'b1 || ready_v !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_start_ignored: got busy=%b prog_n=%b rdy=%b, want 0 1 0", busy_v, prog_n_v, ready_v);
        end
    endtask

    task automatic test_full_load();
        int done_cyc, wr_cnt;
        bit addr_ok, stall_ok, en_seen, verr2;
        fill_ram();
        force_bad = 1'b0;
        run_session(1'b0, -1, 0, 0, done_cyc, wr_cnt, addr_ok, stall_ok, en_seen, verr2);
        n_cmp++;
        if (done_cyc !== 50) begin
            n_bad++;
            $display("FAIL full_done_cycle: got %0d, want 50", done_cyc);
        end
        n_cmp++;
        if (wr_cnt !== 16 || addr_ok !== 1'b1) begin
            n_bad++;
            $display("FAIL full_writes: got count=%0d addr_ok=%b, want 16 1", wr_cnt, addr_ok);
        end
        n_cmp++;
        if (en_seen !== 1'b1) begin
            n_bad++;
            $display("FAIL full_verify_read: got en_seen=%b, want 1", en_seen);
        end
        tick();
        n_cmp++;
        if (verr_v !== 1'b0 || busy_v !== 1'b0 || prog_n_v !== 1'b1) begin
            n_bad++;
            $display("FAIL full_end_state: got verr=%b busy=%b prog_n=%b, want 0 0 1", verr_v, busy_v, prog_n_v);
        end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (mem_v[i] !== 8'(i)) begin
                n_bad++;
                $display("FAIL full_ram[%0d]: got %h, want %h", i, mem_v[i], 8'(i));
            end
        end
    endtask

    task automatic test_stall();
        int done_cyc, wr_cnt;
        bit addr_ok, stall_ok, en_seen, verr2;
        bit ram_ok;
        fill_ram();
        run_session(1'b0, 5, 3, 0, done_cyc, wr_cnt, addr_ok, stall_ok, en_seen, verr2);
        n_cmp++;
        if (stall_ok !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_ready_hold: got stall_ok=%b, want 1", stall_ok);
        end
        n_cmp++;
        if (done_cyc !== 53) begin
            n_bad++;
            $display("FAIL stall_done_cycle: got %0d, want 53", done_cyc);
        end
        tick();
        ram_ok = 1'b1;
        for (int i = 0; i < 16; i++) if (mem_v[i] !== 8'(i)) ram_ok = 1'b0;
        n_cmp++;
        if (ram_ok !== 1'b1 || wr_cnt !== 16 || addr_ok !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_ram: got ram_ok=%b writes=%0d addr_ok=%b, want 1 16 1", ram_ok, wr_cnt, addr_ok);
        end
    endtask

    task automatic test_verify_fail();
        int done_cyc, wr_cnt;
        bit addr_ok, stall_ok, en_seen, verr2;
        fill_ram();
        force_bad = 1'b1;
        run_session(1'b0, -1, 0, 0, done_cyc, wr_cnt, addr_ok, stall_ok, en_seen, verr2);
        n_cmp++;
        if (done_cyc !== 50) begin
            n_bad++;
            $display("FAIL vfail_done_cycle: got %0d, want 50", done_cyc);
        end
        tick();
        n_cmp++;
        if (verr_v !== 1'b1) begin
            n_bad++;
            $display("FAIL vfail_err_set: got %b, want 1", verr_v);
        end
        tick();
        tick();
        tick();
        n_cmp++;
        if (verr_v !== 1'b1) begin
            n_bad++;
            $display("FAIL vfail_err_sticky: got %b, want 1", verr_v);
        end
        force_bad = 1'b0;
        run_session(1'b0, -1, 0, 0, done_cyc, wr_cnt, addr_ok, stall_ok, en_seen, verr2);
        n_cmp++;
        if (verr2 !== 1'b0) begin
            n_bad++;
            $display("FAIL vfail_err_cleared_by_start: got %b, want 0", verr2);
        end
        tick();
        n_cmp++;
        if (verr_v !== 1'b0) begin
            n_bad++;
            $display("FAIL vfail_clean_rerun: got %b, want 0", verr_v);
        end
    endtask

    task automatic test_reset_mid();
        int done_cyc, wr_cnt;
        bit addr_ok, stall_ok, en_seen, verr2;
        bit done_seen;
        bit ram_ok;
        fill_ram();
        run_session(1'b0, -1, 0, 6, done_cyc, wr_cnt, addr_ok, stall_ok, en_seen, verr2);
        n_cmp++;
        if (prog_n_v !== 1'b1 || busy_v !== 1'b0 || wr_v !== 1'b0 || done_v !== 1'b0) begin
            n_bad++;
            $display("FAIL rmid_idle: got prog_n=%b busy=%b wr=%b done=%b, want 1 0 0 0", prog_n_v, busy_v, wr_v, done_v);
        end
        n_cmp++;
        if (wr_cnt !== 6 || done_cyc !== -1) begin
            n_bad++;
            $display("FAIL rmid_progress: got writes=%0d done_cyc=%0d, want 6 -1", wr_cnt, done_cyc);
        end
        done_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (done_v || busy_v) done_seen = 1'b1;
            tick();
        end
        n_cmp++;
        if (done_seen !== 1'b0) begin
            n_bad++;
            $display("FAIL rmid_no_done: got activity=%b, want 0", done_seen);
        end
        ram_ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i < 6 && mem_v[i] !== 8'(i)) ram_ok = 1'b0;
            if (i >= 6 && mem_v[i] !== 8'hAA) ram_ok = 1'b0;
        end
        n_cmp++;
        if (ram_ok !== 1'b1) begin
            n_bad++;
            $display("FAIL rmid_ram: got ram_ok=%b (w5=%h w6=%h), want 1 (05 AA)", ram_ok, mem_v[5], mem_v[6]);
        end
    endtask

    task automatic test_no_verify();
        int done_cyc, wr_cnt;
        bit addr_ok, stall_ok, en_seen, verr2;
        bit ram_ok;
        fill_ram();
        run_session(1'b1, -1, 0, 0, done_cyc, wr_cnt, addr_ok, stall_ok, en_seen, verr2);
        n_cmp++;
        if (done_cyc !== 34) begin
            n_bad++;
            $display("FAIL nover_done_cycle: got %0d, want 34", done_cyc);
        end
        n_cmp++;
        if (en_seen !== 1'b0) begin
            n_bad++;
            $display("FAIL nover_en_ram_out: got %b, want 0", en_seen);
        end
        tick();
        n_cmp++;
        if (verr_n !== 1'b0 || busy_n !== 1'b0) begin
            n_bad++;
            $display("FAIL nover_end_state: got verr=%b busy=%b, want 0 0", verr_n, busy_n);
        end
        ram_ok = 1'b1;
        for (int i = 0; i < 16; i++) if (mem_n[i] !== 8'(i)) ram_ok = 1'b0;
        n_cmp++;
        if (ram_ok !== 1'b1 || wr_cnt !== 16 || addr_ok !== 1'b1) begin
            n_bad++;
            $display("FAIL nover_ram: got ram_ok=%b writes=%0d addr_ok=%b, want 1 16 1", ram_ok, wr_cnt, addr_ok);
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_stall();
        test_verify_fail();
        test_reset_mid();
        test_no_verify();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
